// File: rtl/core_scheduler.sv
// Per-block instruction sequencer: steps every enabled thread lane through
// FETCH..UPDATE in lock-step and reports PC divergence and retirement count.
module core_scheduler #(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int PC_BITS           = 8
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic [$clog2(THREADS_PER_BLOCK):0]     thread_count,
    output logic                                   fetch_req,
    input  logic                                   fetch_done,
    input  logic                                   decoded_ret,
    input  logic [THREADS_PER_BLOCK-1:0]           lsu_busy,
    input  logic [THREADS_PER_BLOCK*PC_BITS-1:0]   next_pc,
    output logic [3:0]                             core_state,
    output logic [PC_BITS-1:0]                     current_pc,
    output logic [THREADS_PER_BLOCK-1:0]           thread_enable,
    output logic                                   done,
    output logic                                   diverged,
    output logic [15:0]                            instr_count
);

    localparam int TC_W = $clog2(THREADS_PER_BLOCK) + 1;

    localparam logic [3:0] ST_IDLE    = 4'b0000;
    localparam logic [3:0] ST_FETCH   = 4'b0001;
    localparam logic [3:0] ST_DECODE  = 4'b0010;
    localparam logic [3:0] ST_ISSUE   = 4'b0011;
    localparam logic [3:0] ST_REQUEST = 4'b0100;
    localparam logic [3:0] ST_WAIT    = 4'b0101;
    localparam logic [3:0] ST_EXECUTE = 4'b0110;
    localparam logic [3:0] ST_UPDATE  = 4'b0111;
    localparam logic [3:0] ST_DONE    = 4'b1000;

    logic [3:0]                   state;
    logic [31:0]                  tc_ext;
    logic [THREADS_PER_BLOCK-1:0] start_mask;
    logic [PC_BITS-1:0]           sel_pc;
    logic                         sel_found;
    logic                         pc_mismatch;

    assign tc_ext = {{(32-TC_W){1'b0}}, thread_count};

    // Lane i is enabled when i < thread_count; since i never reaches
    // THREADS_PER_BLOCK, oversized counts clamp naturally.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        start_mask = '0;
        for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
            if (32'(i) < tc_ext) start_mask[i] = 1'b1;
        end
    end

    // Lowest-index enabled lane supplies the shared PC; any other enabled
    // lane that disagrees flags divergence. Disabled lanes are ignored.
    always_comb begin
        sel_pc      = '0;
        sel_found   = 1'b0;
        pc_mismatch = 1'b0;
        for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
            if (thread_enable[i] && !sel_found) begin
                sel_pc    = next_pc[i*PC_BITS +: PC_BITS];
                sel_found = 1'b1;
            end
        end
        for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
            if (thread_enable[i] && (next_pc[i*PC_BITS +: PC_BITS] != sel_pc))
                pc_mismatch = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            current_pc    <= '0;
            thread_enable <= '0;
            done          <= 1'b0;
            diverged      <= 1'b0;
            instr_count   <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        thread_enable <= start_mask;
                        current_pc    <= '0;
                        diverged      <= 1'b0;
                        instr_count   <= '0;
                        if (|start_mask) begin
                            done  <= 1'b0;
                            state <= ST_FETCH;
                        end else begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end
                    end
                end
                ST_FETCH:   if (fetch_done) state <= ST_DECODE;
                ST_DECODE:  state <= ST_ISSUE;
                ST_ISSUE:   state <= ST_REQUEST;
                ST_REQUEST: state <= ST_WAIT;
                ST_WAIT:    if ((lsu_busy & thread_enable) == '0) state <= ST_EXECUTE;
                ST_EXECUTE: state <= ST_UPDATE;
                ST_UPDATE: begin
                    if (instr_count != 16'hFFFF) instr_count <= instr_count + 16'd1;
                    if (decoded_ret) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        current_pc <= sel_pc;
                        if (pc_mismatch) diverged <= 1'b1;
                        state <= ST_FETCH;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign core_state = state;
    assign fetch_req  = (state == ST_FETCH);

endmodule

// File: tb/tb_core_scheduler.sv
// Self-checking bench for core_scheduler: a behavioural model pushes the
// expected end-of-instruction result to a scoreboard that is popped at UPDATE exit.
module tb_core_scheduler;

    localparam int T = 4;
    localparam int P = 8;

    localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_REQUEST = 4'd4,
                           S_WAIT = 4'd5, S_EXECUTE = 4'd6, S_UPDATE = 4'd7, S_DONE = 4'd8;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [2:0]     thread_count;
    logic           fetch_req;
    logic           fetch_done;
    logic           decoded_ret;
    logic [T-1:0]   lsu_busy;
    logic [T*P-1:0] next_pc;
    logic [3:0]     core_state;
    logic [P-1:0]   current_pc;
    logic [T-1:0]   thread_enable;
    logic           done;
    logic           diverged;
    logic [15:0]    instr_count;

    core_scheduler #(.THREADS_PER_BLOCK(T), .PC_BITS(P)) dut (
        .clk(clk), .reset(reset), .start(start), .thread_count(thread_count),
        .fetch_req(fetch_req), .fetch_done(fetch_done), .decoded_ret(decoded_ret),
        .lsu_busy(lsu_busy), .next_pc(next_pc), .core_state(core_state),
        .current_pc(current_pc), .thread_enable(thread_enable), .done(done),
        .diverged(diverged), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  pc;
        logic        div;
        logic [15:0] cnt;
        logic        dn;
        logic [3:0]  st;
        logic [3:0]  en;
    } exp_t;

    exp_t sb_q[$];

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [3:0]  m_en;
    logic [7:0]  m_pc;
    logic        m_div;
    logic [15:0] m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_start(input int tc);
        int eff;
        start        = 1'b1;
        thread_count = 3'(tc);
        @(negedge clk);
        start = 1'b0;
        eff   = (tc > T) ? T : tc;
        m_en  = 4'((1 << eff) - 1);
        m_pc  = '0;
        m_div = 1'b0;
        m_cnt = '0;
        check("start_state", core_state, (eff == 0) ? S_DONE : S_FETCH);
        check("start_en",    thread_enable, m_en);
        check("start_done",  done, (eff == 0));
        check("start_pc",    current_pc, 0);
        check("start_cnt",   instr_count, 0);
        check("start_div",   diverged, 0);
    endtask

    // Called at a negedge with the DUT in its first FETCH cycle; returns at
    // the negedge after UPDATE.
    task automatic run_instr(input logic [31:0] npc, input logic ret, input logic [3:0] busy,
                             input int fstall, input int exp_wait, input logic pulse);
        exp_t       e;
        logic [7:0] sel;
        logic       found, mm, finished;
        int         cyc, wcyc, fcyc;

        found = 1'b0; sel = '0; mm = 1'b0;
        for (int i = 0; i < T; i++)
            if (m_en[i] && !found) begin sel = npc[i*P +: P]; found = 1'b1; end
        for (int i = 0; i < T; i++)
            if (m_en[i] && (npc[i*P +: P] != sel)) mm = 1'b1;
        e.cnt = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
        e.en  = m_en;
        if (ret) begin
            e.pc = m_pc; e.div = m_div; e.dn = 1'b1; e.st = S_DONE;
        end else begin
            e.pc = sel; e.div = m_div | mm; e.dn = 1'b0; e.st = S_FETCH;
        end
        m_pc = e.pc; m_div = e.div; m_cnt = e.cnt;
        sb_q.push_back(e);

        next_pc     = npc;
        decoded_ret = ret;
        check("enter_fetch", core_state, S_FETCH);
        cyc = 0; wcyc = 0; fcyc = 0; finished = 1'b0;
        while (cyc < 200) begin
            cyc++;
            start = 1'b0;
            check("fetch_req", fetch_req, (core_state == S_FETCH));
            case (core_state)
                S_FETCH:   begin fcyc++; fetch_done = (fcyc > fstall); end
                S_REQUEST: lsu_busy = busy;
                S_WAIT:    begin wcyc++; if (wcyc >= 5) lsu_busy = '0; end
                S_EXECUTE: begin
                    lsu_busy = '0;
                    if (pulse) begin start = 1'b1; thread_count = 3'd0; end
                end
                default: ;
            endcase
            if (core_state == S_UPDATE) begin
                @(negedge clk);
                start    = 1'b0;
                finished = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("instr_timeout", finished, 1'b1);
        fetch_done = 1'b1;

        e = sb_q.pop_front();
        check("instr_cycles", cyc, 6 + fstall + exp_wait);
        check("wait_cycles",  wcyc, exp_wait);
        check("next_state",   core_state, e.st);
        check("pc",           current_pc, e.pc);
        check("diverged",     diverged, e.div);
        check("instr_count",  instr_count, e.cnt);
        check("done",         done, e.dn);
        check("enable_hold",  thread_enable, e.en);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        reset = 1'b0; start = 1'b0; thread_count = '0; fetch_done = 1'b1;
        decoded_ret = 1'b0; lsu_busy = '0; next_pc = '0;
        m_en = '0; m_pc = '0; m_div = 1'b0; m_cnt = '0;
        #3;
        check("rst_state", core_state, S_IDLE);
        check("rst_fetch", fetch_req, 0);
        check("rst_pc",    current_pc, 0);
        check("rst_en",    thread_enable, 0);
        check("rst_done",  done, 0);
        check("rst_div",   diverged, 0);
        check("rst_cnt",   instr_count, 0);
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        check("idle_hold", core_state, S_IDLE);

        // Plain, LSU-stalled, then RET with fetch stall on the 3rd instruction
        do_start(4);
        run_instr({4{8'h01}}, 1'b0, 4'b0000, 0, 1, 1'b0);
        run_instr({4{8'h02}}, 1'b0, 4'b0100, 0, 5, 1'b0);
        run_instr({4{8'h03}}, 1'b1, 4'b0000, 2, 1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("done_hold",  done, 1);
            check("done_state", core_state, S_DONE);
        end

        // Busy on a disabled lane is masked
        do_start(2);
        run_instr({4{8'h04}}, 1'b0, 4'b0100, 0, 1, 1'b0);
        run_instr({4{8'h04}}, 1'b1, 4'b0000, 0, 1, 1'b0);

        // Divergence; thread 3 is disabled and must be ignored
        do_start(3);
        run_instr({8'h09, 8'h05, 8'h05, 8'h05}, 1'b0, 4'b0000, 0, 1, 1'b0);
        run_instr({8'h09, 8'h05, 8'h07, 8'h05}, 1'b0, 4'b0000, 0, 1, 1'b0);
        run_instr({8'h09, 8'h06, 8'h06, 8'h06}, 1'b0, 4'b0000, 0, 1, 1'b0);
        // start during EXECUTE is ignored
        run_instr({8'h09, 8'h08, 8'h08, 8'h08}, 1'b0, 4'b0000, 0, 1, 1'b1);
        run_instr({4{8'h08}}, 1'b1, 4'b0000, 0, 1, 1'b0);
        do_start(0);
        do_start(7);

        // Asynchronous reset while in WAIT, between edges
        lsu_busy = 4'hF;
        k = 0;
        while (core_state != S_WAIT && k < 50) begin @(negedge clk); k++; end
        check("reach_wait", core_state, S_WAIT);
        #2 reset = 1'b0;
        #1;
        check("arst_state", core_state, S_IDLE);
        check("arst_fetch", fetch_req, 0);
        check("arst_pc",    current_pc, 0);
        check("arst_en",    thread_enable, 0);
        check("arst_done",  done, 0);
        check("arst_div",   diverged, 0);
        check("arst_cnt",   instr_count, 0);
        @(negedge clk);
        reset = 1'b1; lsu_busy = '0;
        m_en = '0; m_pc = '0; m_div = 1'b0; m_cnt = '0;
        @(negedge clk);
        check("post_rst_idle", core_state, S_IDLE);
        check("post_rst_en",   thread_enable, 0);
        do_start(4);
        run_instr({4{8'h0A}}, 1'b0, 4'b0000, 0, 1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/core_scheduler.md
CORE_SCHEDULER -- requirements
Module: core_scheduler

Interface
REQ-001 Parameter THREADS_PER_BLOCK, default 4: number of thread lanes (register files) sequenced by this block.
REQ-002 Parameter PC_BITS, default 8: width of the program counter.
REQ-003 Port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 Port reset  in  1  asynchronous, active-low reset.
REQ-005 Port start  in  1  launch request for a new block.
REQ-006 Port thread_count  in  $clog2(THREADS_PER_BLOCK)+1  number of active threads in the block.
REQ-007 Port fetch_req  out  1  instruction fetch request.
REQ-008 Port fetch_done  in  1  fetched instruction is available.
REQ-009 Port decoded_ret  in  1  current instruction is RET.
REQ-010 Port lsu_busy  in  THREADS_PER_BLOCK  per-thread load/store outstanding.
REQ-011 Port next_pc  in  THREADS_PER_BLOCK*PC_BITS  per-thread next PC, packed; thread i occupies bits [i*PC_BITS +: PC_BITS].
REQ-012 Port core_state  out  4  pipeline state, driven to every register file and unit.
REQ-013 Port current_pc  out  PC_BITS  PC of the instruction in flight.
REQ-014 Port thread_enable  out  THREADS_PER_BLOCK  per-lane enable.
REQ-015 Port done  out  1  block finished.
REQ-016 Port diverged  out  1  sticky flag: enabled threads disagreed on next_pc.
REQ-017 Port instr_count  out  16  instructions retired in the current block.

Function
REQ-018 State encodings on core_state: IDLE 0000, FETCH 0001, DECODE 0010, ISSUE 0011, REQUEST 0100, WAIT 0101, EXECUTE 0110, UPDATE 0111, DONE 1000; no other value is ever driven.
REQ-019 In IDLE or DONE, start high at a clock edge: latch thread_enable[i] = (i < min(thread_count, THREADS_PER_BLOCK)); clear current_pc, done, diverged and instr_count; go to FETCH.
REQ-020 In IDLE or DONE with start high and effective thread_count 0: go to DONE with done=1 and thread_enable all zero.
REQ-021 start is ignored in every state other than IDLE and DONE.
REQ-022 fetch_req is high exactly while state is FETCH.
REQ-023 FETCH to DECODE occurs on the first edge at which fetch_done is sampled high; otherwise FETCH holds.
REQ-024 DECODE, ISSUE, REQUEST, EXECUTE and UPDATE each last exactly one cycle, in sequence; REQUEST always proceeds to WAIT.
REQ-025 WAIT proceeds to EXECUTE on the first edge at which (lsu_busy & thread_enable) == 0; otherwise WAIT holds.
REQ-026 Minimum instruction latency is 7 cycles (FETCH through UPDATE), with fetch_done high in the first FETCH cycle and no LSU busy.
REQ-027 UPDATE with decoded_ret=1: go to DONE and set done=1; current_pc is unchanged.
REQ-028 UPDATE with decoded_ret=0: current_pc <= next_pc of the lowest-index enabled thread; go to FETCH.
REQ-029 UPDATE with decoded_ret=0, when any enabled thread's next_pc differs from the selected one: set diverged=1; it holds until the next accepted start.
REQ-030 next_pc slices of disabled threads never affect current_pc or diverged.
REQ-031 instr_count increments by 1 in every UPDATE cycle, including RET, and saturates at 16'hFFFF.
REQ-032 done stays high in DONE until an accepted start.
REQ-033 thread_enable is constant between accepted starts.

Reset
REQ-034 While reset is low, asynchronously: state=IDLE, core_state=0000, current_pc=0, thread_enable=0, fetch_req=0, done=0, diverged=0, instr_count=0.
REQ-035 Reset asserted mid-instruction (any state) aborts the block immediately; after release the block waits in IDLE for start, and no stale state survives.

Verification
REQ-036 thread_count=4, start pulse, fetch_done tied 1, lsu_busy=0, next_pc all 8'h01, decoded_ret=0 -> core_state visits 0001..0111 in 7 cycles; current_pc=1; instr_count=1.
REQ-037 lsu_busy[2] held high 5 cycles after entering WAIT, thread_count=4 -> WAIT lasts 5 cycles, EXECUTE on the 6th; with thread_count=2, the same stimulus leaves WAIT after 1 cycle.
REQ-038 thread_count=3, next_pc = {8'h09, 8'h05, 8'h05, 8'h05} (thread 3 to thread 0) -> current_pc=5, diverged=0; then thread 1 next_pc=8'h07 -> current_pc=5, diverged=1, still 1 after the next instruction.
REQ-039 decoded_ret=1 on the 3rd instruction -> state DONE, done=1, instr_count=3; start again -> done=0, instr_count=0, current_pc=0, FETCH.
REQ-040 Reset driven low while in WAIT, between clock edges -> core_state=0000 and all outputs zero before the next edge; start after release -> normal sequence from PC 0.
REQ-041 start pulsed during EXECUTE, and thread_count=0 at start -> the first has no effect; the second goes directly to DONE with thread_enable=0.
